line_buffer: RTL

//  Vertical window generator for the image_processor pixel stream: stores the

---
 rtl/image_processor_pkg.sv | 18 +
 rtl/ram_dc.sv | 41 ++++
 rtl/line_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/image_processor_pkg.sv
// ---------------------------------------------------------------------------
// image_processor_pkg
//   Shared definitions for the image_processor pixel pipeline.
//   PIXEL_BITW : default bits per pixel
//   pixel_t    : one pixel word at the default width
//   VCNT_BITW  : width of the vertical (line) counter
//   VCNT_MAX   : saturation value of the vertical counter
// ---------------------------------------------------------------------------
package image_processor_pkg;

   localparam int PIXEL_BITW = 8;

   typedef logic [PIXEL_BITW-1:0] pixel_t;

   localparam int VCNT_BITW = 16;
   localparam logic [VCNT_BITW-1:0] VCNT_MAX = '1;

endpackage

// File: rtl/ram_dc.sv
// ---------------------------------------------------------------------------
// ram_dc
//   Simple dual-port, dual-clock RAM with a registered read port.
//   A read and a write to the same word on the same edge return the OLD word
//   (read-before-write).
//   wr_clock  : write clock
//   wr_enable : write strobe
//   wr_addr   : write address
//   wr_data   : write data
//   rd_clock  : read clock
//   rd_enable : read strobe; rd_data holds its value when low
//   rd_addr   : read address
//   rd_data   : registered read data
// ---------------------------------------------------------------------------
module ram_dc #(
   parameter int WORD_SIZE = 8,
   parameter int RAM_SIZE  = 1024
) (
   input  logic                        wr_clock,
   input  logic                        wr_enable,
   input  logic [$clog2(RAM_SIZE)-1:0] wr_addr,
   input  logic [WORD_SIZE-1:0]        wr_data,
   input  logic                        rd_clock,
   input  logic                        rd_enable,
   input  logic [$clog2(RAM_SIZE)-1:0] rd_addr,
   output logic [WORD_SIZE-1:0]        rd_data
);

   logic [WORD_SIZE-1:0] mem [RAM_SIZE];

   always_ff @(posedge wr_clock) begin
      if (wr_enable) mem[wr_addr] <= wr_data;
   end

   // Separate process from the write: a same-edge read samples mem before
   // the write's non-blocking update lands, giving read-before-write.
   always_ff @(posedge rd_clock) begin
      if (rd_enable) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
//   Vertical window generator. Stores the previous LINES-1 lines in a chain
//   of ram_dc instances and emits, one cycle after each accepted pixel, a
//   LINES-tall column at the same x.
//   clock      : single clock, rising edge
//   n_rst      : asynchronous reset, active low
//   width      : line width, sampled only with in_sof & in_enable
//   in_enable  : pixel valid (no backpressure)
//   in_sof     : first pixel of frame, qualified by in_enable
//   in_pixel   : pixel data
//   out_valid  : column valid
//   out_column : [k*PIXEL_BITW +: PIXEL_BITW] = row y-k, k=0 newest
//   out_hcnt   : x of out_column
//   out_vcnt   : y of out_column (saturating)
// ---------------------------------------------------------------------------
module line_buffer #(
   parameter int WIDTH_MAX  = 1024,
   parameter int PIXEL_BITW = image_processor_pkg::PIXEL_BITW,
   parameter int LINES      = 3
) (
   input  logic                               clock,
   input  logic                               n_rst,
   input  logic [$clog2(WIDTH_MAX):0]         width,
   input  logic                               in_enable,
   input  logic                               in_sof,
   input  logic [PIXEL_BITW-1:0]              in_pixel,
   output logic                               out_valid,
   output logic [LINES*PIXEL_BITW-1:0]        out_column,
   output logic [$clog2(WIDTH_MAX)-1:0]       out_hcnt,
   output logic [image_processor_pkg::VCNT_BITW-1:0] out_vcnt
);

   import image_processor_pkg::*;

   localparam int ADDR_BITW = $clog2(WIDTH_MAX);
   localparam int WBITS     = ADDR_BITW + 1;
   localparam logic [WBITS-1:0] WIDTH_FULL = WBITS'(WIDTH_MAX);

   logic                  start;
   logic [WBITS-1:0]      width_reg;
   logic [WBITS-1:0]      width_clamped;
   logic [WBITS-1:0]      width_eff;
   logic [ADDR_BITW-1:0]  hcnt;
   logic [ADDR_BITW-1:0]  cur_x;
   logic [ADDR_BITW-1:0]  next_x;
   logic [VCNT_BITW-1:0]  vcnt;
   logic [VCNT_BITW-1:0]  cur_y;
   logic [VCNT_BITW-1:0]  next_y;
   logic [PIXEL_BITW-1:0] pixel_d1;
   logic                  chain_en;
   logic                  column_live;
   logic [PIXEL_BITW-1:0] rd_data [LINES-1];

   // A start-of-frame pixel is itself position (0,0) and uses the freshly
   // clamped width, so the wrap decision for it already sees the new line length.
   always_comb begin
      start         = in_enable & in_sof;
      width_clamped = (width == '0 || width > WIDTH_FULL) ? WIDTH_FULL : width;
      width_eff     = start ? width_clamped : width_reg;
      cur_x         = start ? '0 : hcnt;
      cur_y         = start ? '0 : vcnt;
      if ({1'b0, cur_x} == width_eff - WBITS'(1)) begin
         next_x = '0;
         next_y = (cur_y == VCNT_MAX) ? cur_y : cur_y + VCNT_BITW'(1);
      end else begin
         next_x = cur_x + ADDR_BITW'(1);
         next_y = cur_y;
      end
   end

   // out_hcnt doubles as the registered x used by the chained RAM writes.
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         hcnt        <= '0;
         vcnt        <= '0;
         width_reg   <= WIDTH_FULL;
         out_valid   <= 1'b0;
         out_hcnt    <= '0;
         out_vcnt    <= '0;
         pixel_d1    <= '0;
         chain_en    <= 1'b0;
         column_live <= 1'b0;
      end else begin
         out_valid <= in_enable;
         chain_en  <= in_enable;
         if (in_enable) begin
            hcnt        <= next_x;
            vcnt        <= next_y;
            width_reg   <= width_eff;
            out_hcnt    <= cur_x;
            out_vcnt    <= cur_y;
            pixel_d1    <= in_pixel;
            column_live <= 1'b1;
         end
      end
   end

   // RAM0 captures the incoming line; each later RAM takes the word its
   // predecessor just read out, one cycle later at the registered x.
   for (genvar k = 0; k < LINES-1; k++) begin : g_ram
      logic                  wr_en;
      logic [ADDR_BITW-1:0]  wr_addr;
      logic [PIXEL_BITW-1:0] wr_data;

      if (k == 0) begin : g_head
         assign wr_en   = in_enable;
         assign wr_addr = cur_x;
         assign wr_data = in_pixel;
      end else begin : g_chain
         assign wr_en   = chain_en;
         assign wr_addr = out_hcnt;
         assign wr_data = rd_data[k-1];
      end

      ram_dc #(
         .WORD_SIZE (PIXEL_BITW),
         .RAM_SIZE  (WIDTH_MAX)
      ) u_ram (
         .wr_clock  (clock),
         .wr_enable (wr_en),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .rd_clock  (clock),
         .rd_enable (in_enable),
         .rd_addr   (cur_x),
         .rd_data   (rd_data[k])
      );
   end

   // RAM read registers are not reset, so the column reads zero until the
   // first pixel after reset has been accepted.
   always_comb begin
      out_column = '0;
      if (column_live) begin
         out_column[PIXEL_BITW-1:0] = pixel_d1;
         for (int k = 0; k < LINES-1; k++) begin
            out_column[(k+1)*PIXEL_BITW +: PIXEL_BITW] = rd_data[k];
         end
      end
   end

endmodule
